// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over one shared 64-bit working register, with a start/busy/done handshake.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] r_o
);

  // state | meaning
  // IDLE  | waiting for start; special cases resolved here
  // RUN   | one shift-add / shift-subtract iteration per cycle, 32 cycles
  // DONE  | done pulse, r holds the new result
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] r_q, r_d;

  logic        is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, neg_in;
  logic [31:0] a_mag_in, b_mag_in;
  logic        div_zero_in, div_ovf_in;
  logic [31:0] special_res;

  always_comb begin
    a_sgn_in = 1'b0;
    b_sgn_in = 1'b0;
    case (funct3_i)
      3'b001:  begin a_sgn_in = 1'b1; b_sgn_in = 1'b1; end
      3'b010:  a_sgn_in = 1'b1;
      3'b100:  begin a_sgn_in = 1'b1; b_sgn_in = 1'b1; end
      3'b110:  begin a_sgn_in = 1'b1; b_sgn_in = 1'b1; end
      default: begin a_sgn_in = 1'b0; b_sgn_in = 1'b0; end
    endcase
  end

  assign is_div_in   = funct3_i[2];
  assign a_neg_in    = a_sgn_in & a_i[31];
  assign b_neg_in    = b_sgn_in & b_i[31];
  assign a_mag_in    = a_neg_in ? (32'd0 - a_i) : a_i;
  assign b_mag_in    = b_neg_in ? (32'd0 - b_i) : b_i;
  // Remainder takes the dividend's sign; everything else the XOR of both.
  assign neg_in      = (is_div_in & funct3_i[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
  assign div_zero_in = is_div_in & (b_i == 32'd0);
  assign div_ovf_in  = is_div_in & ~funct3_i[0] & (a_i == 32'h8000_0000) &
                       (b_i == 32'hFFFF_FFFF);
  assign special_res = div_zero_in ? (funct3_i[1] ? a_i : 32'hFFFF_FFFF)
                                   : (funct3_i[1] ? 32'd0 : 32'h8000_0000);

  // Multiply: work = {acc, multiplier}; divide: work = {rem, quot}.
  logic [32:0] add_sum;
  logic [63:0] mul_next, div_next, iter_next;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_diff;

  assign add_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {add_sum, work_q[31:1]};

  // The shifted remainder needs 33 bits when the divisor exceeds 2^31.
  assign rem_sh   = work_q[63:31];
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh[31:0] - opnd_q;
  assign div_next = rem_ge ? {rem_diff, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};

  assign iter_next = op_q[2] ? div_next : mul_next;

  logic [63:0] mul_res64;
  logic [31:0] div_sel, div_res, run_res;

  assign mul_res64 = neg_q ? (64'd0 - iter_next) : iter_next;
  assign div_sel   = op_q[1] ? iter_next[63:32] : iter_next[31:0];
  assign div_res   = neg_q ? (32'd0 - div_sel) : div_sel;
  assign run_res   = op_q[2] ? div_res
                   : ((op_q[1:0] == 2'b00) ? mul_res64[31:0] : mul_res64[63:32]);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    neg_d   = neg_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d  = funct3_i;
          neg_d = neg_in;
          if (div_zero_in | div_ovf_in) begin
            r_d     = special_res;
            state_d = DONE;
          end else begin
            state_d = RUN;
            count_d = 5'd0;
            work_d  = {32'd0, (is_div_in ? a_mag_in : b_mag_in)};
            opnd_d  = is_div_in ? b_mag_in : a_mag_in;
          end
        end
      end
      RUN: begin
        work_d  = iter_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          r_d     = run_res;
          count_d = 5'd0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a start in IDLE.
    if (kill_i) begin
      state_d = IDLE;
      count_d = 5'd0;
      r_d     = r_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      work_q  <= 64'd0;
      opnd_q  <= 32'd0;
      r_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      r_q     <= r_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign r_o    = r_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, special cases, kill,
// ignored start while busy and asynchronous reset mid-operation.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i, b_i;
  logic        kill_i;
  logic        busy_o, done_o;
  logic [31:0] r_o;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .r_o      (r_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op from IDLE; cycle 1 is the cycle right after the accepting edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int n;
    int busy_cnt;
    start_i  = 1'b1;
    funct3_i = op;
    a_i      = a;
    b_i      = b;
    tick();
    start_i  = 1'b0;
    n        = 1;
    busy_cnt = 0;
    while (!done_o && n < 40) begin
      if (busy_o) busy_cnt++;
      tick();
      n++;
    end
    if (busy_o) busy_cnt++;
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_r"}, r_o, exp_r);
    check_eq({tag, "_busycyc"}, busy_cnt, exp_lat);
    tick();
    check_eq({tag, "_idle"}, {30'd0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcnt;
    int first;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    kill_i   = 1'b0;
    funct3_i = 3'd0;
    a_i      = 32'd0;
    b_i      = 32'd0;
    #12;
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_r", r_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 33);
    run_op("mulhu2", 3'b011, 32'h8000_0000, 32'd2,          32'h0000_0001, 33);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33);
    run_op("divu",   3'b101, 32'd100,        32'd7,          32'd14,        33);
    run_op("divubig",3'b101, 32'hFFFF_FFFE, 32'h8000_0001, 32'd1,         33);
    run_op("divu0",  3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,          32'd0,          32'd5,         1);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("remu",   3'b111, 32'd100,        32'd7,          32'd2,         33);

    // Kill 10 cycles into a DIV.
    start_i  = 1'b1;
    funct3_i = 3'b100;
    a_i      = 32'd100;
    b_i      = 32'd7;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    check_eq("kill_pre_busy", {31'd0, busy_o}, 32'd1);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check_eq("kill_busy", {31'd0, busy_o}, 32'd0);
    check_eq("kill_r", r_o, 32'd2);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) dcnt++;
      tick();
    end
    check_eq("kill_nodone", dcnt, 0);

    // Start and kill together in IDLE: not accepted.
    start_i = 1'b1;
    kill_i  = 1'b1;
    tick();
    start_i = 1'b0;
    kill_i  = 1'b0;
    check_eq("startkill_busy", {31'd0, busy_o}, 32'd0);

    // A second start while busy is ignored.
    start_i  = 1'b1;
    funct3_i = 3'b000;
    a_i      = 32'd7;
    b_i      = 32'hFFFF_FFFD;
    tick();
    start_i = 1'b0;
    n = 1;
    repeat (4) begin tick(); n++; end
    start_i  = 1'b1;
    funct3_i = 3'b101;
    a_i      = 32'd5;
    b_i      = 32'd0;
    tick();
    n++;
    start_i = 1'b0;
    dcnt  = 0;
    first = 0;
    while (n <= 45) begin
      if (done_o) begin
        dcnt++;
        if (first == 0) first = n;
      end
      tick();
      n++;
    end
    check_eq("ign_ndone", dcnt, 1);
    check_eq("ign_lat", first, 33);
    check_eq("ign_r", r_o, 32'hFFFF_FFEB);

    // Asynchronous reset between edges during a MUL.
    run_op("premul", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    start_i  = 1'b1;
    funct3_i = 3'b000;
    a_i      = 32'd3;
    b_i      = 32'd5;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("arst_done", {31'd0, done_o}, 32'd0);
    check_eq("arst_r", r_o, 32'd0);
    #2;
    rst_ni = 1'b1;
    tick();
    check_eq("arst_idle", {31'd0, busy_o}, 32'd0);
    run_op("postmul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
